// File: rtl/spi_reg_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | spi_reg_ctrl_pkg : states, frame fields and constants of the      |
// |                    SPI register controller. Rev 1.0               |
// +------------------------------------------------------------------+
`default_nettype none

package spi_reg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic [6:0] CLR_ERR_ADDR  = 7'h7F;
  localparam int         SETTLE_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/spi_busy_sync.sv
// +------------------------------------------------------------------+
// | spi_busy_sync : 2-FF synchronizer for the SPI busy level with     |
// |                 rise/fall pulses in the clk domain. Rev 1.0       |
// +------------------------------------------------------------------+
`default_nettype none

module spi_busy_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
// +------------------------------------------------------------------+
// | spi_reg_ctrl : sequences SPI slave frames and owns the PWM config |
// |   register bank. Optional watchdog: SPI_REG_CTRL_WDT_EN. Rev 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int NREG       = 8,
  parameter int WDT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_busy,
  input  logic [15:0]       spi_rx,
  output logic              spi_rx_enable,
  output logic [15:0]       spi_tx,
  output logic [NREG*8-1:0] regs,
  output logic              frame_done,
  output logic              err,
  output logic              wdt_trip
);

  logic busy_s, busy_rise, unused_fall;

  spi_busy_sync u_busy_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (spi_busy),
    .sync_out (busy_s),
    .rise     (busy_rise),
    .fall     (unused_fall)
  );

  state_e            state_q, state_d;
  logic [1:0]        settle_q, settle_d;
  logic [15:0]       rx_q, rx_d;
  logic [15:0]       tx_q, tx_d;
  logic [7:0]        rb_q, rb_d;
  logic [NREG*8-1:0] regs_q, regs_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              rx_en_q, rx_en_d;
  logic              wr_hit;

  logic [6:0] addr_w;
  logic [7:0] data_w;
  logic       rw_w;
  logic       in_range_w;

  assign addr_w     = rx_q[ADDR_MSB:ADDR_LSB];
  assign data_w     = rx_q[DATA_MSB:DATA_LSB];
  assign rw_w       = rx_q[RW_BIT];
  assign in_range_w = (32'(addr_w) < NREG);

`ifdef SPI_REG_CTRL_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             wdt_trip_q, wdt_trip_d;
`else
  logic unused_wdt;
  assign unused_wdt = (WDT_CYCLES == 0);
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    rb_d     = rb_q;
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ovr_d    = ovr_q;
    done_d   = 1'b0;
    wr_hit   = 1'b0;

    case (state_q)
      ST_IDLE:   if (busy_s) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!busy_s) begin
        state_d  = ST_SETTLE;
        settle_d = 2'd0;
      end
      ST_SETTLE: begin
        if (settle_q == 2'(SETTLE_CYCLES - 1)) state_d = ST_DECODE;
        else settle_d = settle_q + 2'd1;
      end
      ST_DECODE: begin
        rx_d    = spi_rx;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (in_range_w) begin
          if (rw_w) begin
            regs_d[{addr_w, 3'b000} +: 8] = data_w;
            rb_d   = data_w;
            wr_hit = 1'b1;
          end else begin
            rb_d = regs_q[{addr_w, 3'b000} +: 8];
          end
        end else if (rw_w && addr_w == CLR_ERR_ADDR && data_w == 8'h00) begin
          err_d = 1'b0;
          rb_d  = 8'h00;
        end else begin
          err_d = 1'b1;
          rb_d  = 8'h00;
        end
        // An overrun seen earlier in this frame outranks an error-clear command
        if (ovr_q) err_d = 1'b1;
        cnt_d   = cnt_q + 7'd1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        tx_d    = {err_q, cnt_q, rb_q};
        done_d  = 1'b1;
        state_d = (busy_s || ovr_q) ? ST_ACTIVE : ST_IDLE;
        ovr_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (busy_rise && (state_q inside {ST_SETTLE, ST_DECODE, ST_EXEC, ST_RESP})) begin
      err_d = 1'b1;
      if (state_q != ST_RESP) ovr_d = 1'b1;
    end

`ifdef SPI_REG_CTRL_WDT_EN
    wdt_trip_d = 1'b0;
    if (wr_hit) begin
      wdt_d = '0;
    end else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
      wdt_d      = '0;
      regs_d     = '0;
      err_d      = 1'b1;
      wdt_trip_d = 1'b1;
    end else begin
      wdt_d = wdt_q + 1'b1;
    end
`endif

    rx_en_d = (state_d inside {ST_IDLE, ST_ACTIVE, ST_SETTLE});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      settle_q <= 2'd0;
      rx_q     <= 16'h0000;
      tx_q     <= 16'h0000;
      rb_q     <= 8'h00;
      regs_q   <= '0;
      cnt_q    <= 7'd0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      done_q   <= 1'b0;
      rx_en_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      rb_q     <= rb_d;
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
      done_q   <= done_d;
      rx_en_q  <= rx_en_d;
    end
  end

`ifdef SPI_REG_CTRL_WDT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdt_q      <= '0;
      wdt_trip_q <= 1'b0;
    end else begin
      wdt_q      <= wdt_d;
      wdt_trip_q <= wdt_trip_d;
    end
  end
  assign wdt_trip = wdt_trip_q;
`else
  assign wdt_trip = 1'b0;
`endif

  assign spi_rx_enable = rx_en_q;
  assign spi_tx        = tx_q;
  assign regs          = regs_q;
  assign frame_done    = done_q;
  assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
// +------------------------------------------------------------------+
// | tb_spi_reg_ctrl : scoreboard bench for spi_reg_ctrl. Rev 1.0      |
// +------------------------------------------------------------------+
`default_nettype none

module tb_spi_reg_ctrl;
  import spi_reg_ctrl_pkg::*;

  localparam int NREG = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              spi_busy = 1'b0;
  logic [15:0]       spi_rx = 16'h0000;
  logic              spi_rx_enable;
  logic [15:0]       spi_tx;
  logic [NREG*8-1:0] regs;
  logic              frame_done;
  logic              err;
  logic              wdt_trip;

  spi_reg_ctrl #(.NREG(NREG), .WDT_CYCLES(100)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .spi_busy      (spi_busy),
    .spi_rx        (spi_rx),
    .spi_rx_enable (spi_rx_enable),
    .spi_tx        (spi_tx),
    .regs          (regs),
    .frame_done    (frame_done),
    .err           (err),
    .wdt_trip      (wdt_trip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int trip_cnt = 0;

  always @(posedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (wdt_trip === 1'b1) trip_cnt++;
  end

  typedef struct packed {
    logic [15:0]       tx;
    logic [NREG*8-1:0] regs;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_regs [NREG];
  logic       m_err;
  logic [6:0] m_cnt;

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_err = 1'b0;
    m_cnt = 7'd0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic [15:0] w);
    exp_t       e;
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] rb;
    a  = w[14:8];
    d  = w[7:0];
    rb = 8'h00;
    if (int'(a) < NREG) begin
      if (w[15]) m_regs[a] = d;
      rb = m_regs[a];
    end else if (w[15] && a == 7'h7F && d == 8'h00) begin
      m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    m_cnt = m_cnt + 7'd1;
    e.tx = {m_err, m_cnt, rb};
    for (int i = 0; i < NREG; i++) e.regs[i*8 +: 8] = m_regs[i];
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    spi_busy = 1'b0;
    spi_rx   = 16'h0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] w);
    @(negedge clk);
    spi_busy = 1'b1;
    spi_rx   = w;
    repeat (3) @(negedge clk);
    spi_busy = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (frame_done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: frame_done got %b expected 1 within 60 cycles", name, frame_done);
      return;
    end
    checks++;
    if (spi_tx !== e.tx) begin
      errors++;
      $display("FAIL %s_tx: got %h expected %h", name, spi_tx, e.tx);
    end
    checks++;
    if (regs !== e.regs) begin
      errors++;
      $display("FAIL %s_regs: got %h expected %h", name, regs, e.regs);
    end
  endtask

  task automatic do_frame(input logic [15:0] w, input string name);
    model_push(w);
    send_frame(w);
    wait_done(name);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (regs !== '0) begin errors++; $display("FAIL rst_regs: got %h expected 0", regs); end
    checks++; if (spi_tx !== 16'h0000) begin errors++; $display("FAIL rst_tx: got %h expected 0000", spi_tx); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", frame_done); end
    checks++; if (spi_rx_enable !== 1'b1) begin errors++; $display("FAIL rst_rxen: got %b expected 1", spi_rx_enable); end
    checks++; if (wdt_trip !== 1'b0) begin errors++; $display("FAIL rst_wdt: got %b expected 0", wdt_trip); end
  endtask

  task automatic test_write();
    apply_reset();
    do_frame(16'h8212, "write");
    checks++;
    if (regs[23:16] !== 8'h12) begin errors++; $display("FAIL write_reg2: got %h expected 12", regs[23:16]); end
    checks++;
    if (spi_tx !== 16'h0112) begin errors++; $display("FAIL write_resp: got %h expected 0112", spi_tx); end
  endtask

  task automatic test_read();
    apply_reset();
    do_frame(16'h8305, "rd_wr");
    do_frame(16'h0300, "rd_rd");
    checks++;
    if (spi_tx[7:0] !== 8'h05) begin errors++; $display("FAIL read_rb: got %h expected 05", spi_tx[7:0]); end
  endtask

  task automatic test_error();
    apply_reset();
    do_frame(16'h8A55, "oor");
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", err); end
    do_frame(16'hFF00, "clr");
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL clr_err: got %b expected 0", err); end
  endtask

  task automatic test_overrun();
    int base;
    apply_reset();
    base = done_cnt;
    m_err = 1'b1;
    model_push(16'h8144);
    model_push(16'h8255);
    send_frame(16'h8144);
    repeat (3) @(negedge clk);
    spi_busy = 1'b1;
    wait_done("ovr_a");
    checks++;
    if (dut.state_q !== ST_ACTIVE) begin
      errors++;
      $display("FAIL ovr_state: got %0d expected %0d", dut.state_q, ST_ACTIVE);
    end
    repeat (2) @(negedge clk);
    spi_rx   = 16'h8255;
    spi_busy = 1'b0;
    wait_done("ovr_b");
    repeat (10) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ovr_err: got %b expected 1", err); end
    checks++;
    if (done_cnt - base !== 2) begin errors++; $display("FAIL ovr_frames: got %0d expected 2", done_cnt - base); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int base;
    apply_reset();
    do_frame(16'h8312, "pre_rst");
    base = done_cnt;
    send_frame(16'h8477);
    n = 0;
    while (dut.state_q !== ST_SETTLE && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dut.state_q !== ST_SETTLE) begin errors++; $display("FAIL mid_settle: state %0d expected %0d", dut.state_q, ST_SETTLE); end
    reset_n = 1'b0;
    #1;
    checks++; if (regs !== '0) begin errors++; $display("FAIL mid_regs: got %h expected 0", regs); end
    checks++; if (spi_tx !== 16'h0000) begin errors++; $display("FAIL mid_tx: got %h expected 0000", spi_tx); end
    checks++; if (spi_rx_enable !== 1'b1) begin errors++; $display("FAIL mid_rxen: got %b expected 1", spi_rx_enable); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    repeat (25) @(negedge clk);
    checks++;
    if (done_cnt !== base) begin errors++; $display("FAIL mid_done: got %0d frames expected %0d", done_cnt, base); end
    checks++;
    if (regs !== '0) begin errors++; $display("FAIL mid_regs_after: got %h expected 0", regs); end
  endtask

`ifdef SPI_REG_CTRL_WDT_EN
  task automatic test_wdt();
    int n;
    int base;
    apply_reset();
    base = trip_cnt;
    model_push(16'h8107);
    send_frame(16'h8107);
    wait_done("wdt_wr");
    n = 0;
    while (wdt_trip !== 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wdt_trip !== 1'b1 || n < 95 || n > 103) begin
      errors++;
      $display("FAIL wdt_time: trip %b after %0d cycles expected 1 after 95..103", wdt_trip, n);
    end
    checks++; if (regs !== '0) begin errors++; $display("FAIL wdt_regs: got %h expected 0", regs); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wdt_err: got %b expected 1", err); end
    repeat (40) @(negedge clk);
    checks++;
    if (trip_cnt - base !== 1) begin errors++; $display("FAIL wdt_once: got %0d trips expected 1", trip_cnt - base); end

    apply_reset();
    base = trip_cnt;
    for (int i = 0; i < 5; i++) begin
      do_frame(16'h8100 | 16'(i + 1), "wdt_kick");
      repeat (25) @(negedge clk);
    end
    checks++;
    if (trip_cnt !== base) begin errors++; $display("FAIL wdt_kicked: got %0d trips expected 0", trip_cnt - base); end
  endtask
`else
  task automatic test_wdt();
    int base;
    apply_reset();
    base = trip_cnt;
    do_frame(16'h8107, "nowdt_wr");
    repeat (150) @(negedge clk);
    checks++;
    if (trip_cnt !== base) begin errors++; $display("FAIL nowdt_trip: got %0d trips expected 0", trip_cnt - base); end
    checks++;
    if (regs[15:8] !== 8'h07) begin errors++; $display("FAIL nowdt_regs: got %h expected 07", regs[15:8]); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error();
    test_overrun();
    test_reset_mid_frame();
    test_wdt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
